integer_square: RTL and testbench
=================================

// Module: integer_square
// PURPOSE
//  Inverse of the integer square-root unit. Rebuilds the radicand from a (root, remainder) pair: data_out = root*root + remainder.
//  Iterative shift-add, one root bit per clock, start/ready handshake.
//  Sits behind the sqrt datapath as a self-check stage, and as a stand-alone squarer for the DSD datapath.
// PARAMETERS
//  WIDTH      32          radicand / data_out / remainder width in bits
//  ROOT_WIDTH WIDTH/2     root width in bits; equals the iteration count of the multiply phase
// PORTS
//  clk        in   1           clock; all state changes on its rising edge
//  rst        in   1           synchronous, active-high reset
//  stall      in   1           synchronous abort; lower priority than rst, higher priority than start
//  start      in   1           request; accepted only in IDLE
//  root       in   ROOT_WIDTH  unsigned root operand
//  remainder  in   WIDTH       remainder operand; treated as unsigned bits
//  data_out   out  WIDTH       root*root + remainder, low WIDTH bits
//  ready      out  1           result valid (level)
//  busy       out  1           operation in progress
//  overflow   out  1           true sum needed more than WIDTH bits; valid while ready=1
//  err        out  1           invalid (root, remainder) pair; valid while ready=1
// BEHAVIOUR
//  Reset: rst=1 at an edge gives state=IDLE and clears data_out, ready, busy, overflow, err and all internal registers.
//  Stall: stall=1 at an edge has the same effect as rst, but only when rst=0. It applies in any state.
//  States and transitions:
//   IDLE: start=1 latches root into mult, remainder into addend, zeroes the (WIDTH+1)-bit acc, cnt=ROOT_WIDTH-1.
//         Same edge: busy<=1, ready<=0, goto MUL. With start=0, outputs hold; ready stays at its level.
//   MUL:  each edge does acc = (acc<<1) + (root_bit[cnt] ? mult : 0), MSB first.
//         cnt==0 gives goto ADD, otherwise cnt-1. Runs exactly ROOT_WIDTH edges.
//   ADD:  sum = acc + addend, computed WIDTH+1 bits wide.
//         data_out<=sum[WIDTH-1:0], overflow<=sum[WIDTH], ready<=1, busy<=0, goto IDLE.
//  Latency: accept edge E0. ready and data_out are visible after edge E(ROOT_WIDTH+1), i.e. E17 at the default widths.
//  Throughput: one operation per ROOT_WIDTH+2 cycles. start on the edge after ready is legal.
//  start while busy=1 is ignored; no queuing. Operands are sampled only on the accept edge.
//  acc never exceeds 2*ROOT_WIDTH bits. When 2*ROOT_WIDTH<=WIDTH, a valid pair never overflows.
//   Max valid pair: root=2^ROOT_WIDTH-1, remainder=2*root, giving sum=2^WIDTH-1 exactly.
//  Outputs hold their values from ADD until the next accept, stall or rst.
// CONFIGURATION
//  INTEGER_SQUARE_CHECK_EN defined:
//   - on the accept edge, register bad = remainder[WIDTH-1] | (remainder > {root,1'b0}).
//   - ADD copies bad to err.
//   - err clears with ready (on accept, stall or rst).
//  Not defined: err is tied 0. No comparator or bad register is built.
// STRUCTURE
//  Shared package dsd_pkg:
//   - state enum IDLE/MUL/ADD (2 bits); localparam ISQ_ROOT_W = WIDTH/2.
//   - function clog2 for the cnt width.
//  Single module, no sub-modules. The shift-add step is an always-block expression.
//  A separate multiplier module is not warranted.
// TESTING
//  1. root=0, remainder=0, start pulse: ready after 17 edges, data_out=0, overflow=0, err=0.
//  2. root=1234, remainder=100: data_out=1522856 (0x00173CA8), busy high for E1..E17 only.
//  3. root=65535, remainder=131070: data_out=0xFFFFFFFF, overflow=0, err=0.
//  4. root=65535, remainder=131071: data_out=0, overflow=1, err=1 with INTEGER_SQUARE_CHECK_EN (0 without).
//     root=5, remainder=-1: err=1, overflow=1.
//  5. start root=7, rem=3, then stall=1 at E5: busy=0, ready=0, data_out=0.
//     New start root=9, rem=0: data_out=81 after 17 edges.
//     Extra start pulses during busy: no effect on the result or on timing.
//  6. rst at E8 mid-op: all outputs 0 on the next cycle.
//     Round-trip: 1000 random data_in through the sqrt unit into this block; data_out==data_in, overflow=0, err=0.

Source files
------------

// File: rtl/dsd_pkg.sv
// Shared definitions for the DSD datapath: integer_square FSM states,
// default widths and a constant-width helper.
package dsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } isq_state_e;

    localparam int ISQ_WIDTH  = 32;
    localparam int ISQ_ROOT_W = ISQ_WIDTH / 2;

    // Ceiling log2, floored at 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/integer_square.sv
// Rebuilds a radicand from (root, remainder): data_out = root*root + remainder,
// one root bit per clock. Define INTEGER_SQUARE_CHECK_EN to build the pair-validity flag.
import dsd_pkg::*;

module integer_square #(
    parameter int WIDTH      = ISQ_WIDTH,
    parameter int ROOT_WIDTH = WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  start,
    input  logic [ROOT_WIDTH-1:0] root,
    input  logic [WIDTH-1:0]      remainder,
    output logic [WIDTH-1:0]      data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  overflow,
    output logic                  err
);

    localparam int CNT_W = clog2(ROOT_WIDTH);

    isq_state_e            state_q;
    logic [ROOT_WIDTH-1:0] mult_q;
    logic [WIDTH-1:0]      addend_q;
    logic [WIDTH:0]        acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]      data_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  ovf_q;

    logic [WIDTH:0]        acc_d;
    logic [WIDTH:0]        sum_d;
    logic [WIDTH:0]        partial_d;

    // Shift-add step: MSB-first, so after ROOT_WIDTH steps acc = mult*mult.
    always_comb begin
        partial_d = '0;
        if (mult_q[cnt_q]) begin
            partial_d = {{(WIDTH + 1 - ROOT_WIDTH){1'b0}}, mult_q};
        end
        acc_d = (acc_q << 1) + partial_d;
        sum_d = acc_q + {1'b0, addend_q};
    end

`ifdef INTEGER_SQUARE_CHECK_EN
    logic           bad_q;
    logic           err_q;
    logic           bad_d;
    logic [WIDTH:0] root_x2;

    // A valid remainder never exceeds 2*root and is never negative as a signed value.
    always_comb begin
        root_x2 = {{(WIDTH - ROOT_WIDTH){1'b0}}, root, 1'b0};
        bad_d   = remainder[WIDTH-1] | ({1'b0, remainder} > root_x2);
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || stall) begin
            state_q  <= IDLE;
            mult_q   <= '0;
            addend_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef INTEGER_SQUARE_CHECK_EN
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mult_q   <= root;
                        addend_q <= remainder;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(ROOT_WIDTH - 1);
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
`ifdef INTEGER_SQUARE_CHECK_EN
                        bad_q    <= bad_d;
                        err_q    <= 1'b0;
`endif
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= ADD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ADD: begin
                    data_q  <= sum_d[WIDTH-1:0];
                    ovf_q   <= sum_d[WIDTH];
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
`ifdef INTEGER_SQUARE_CHECK_EN
                    err_q   <= bad_q;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_integer_square.sv
// Self-checking bench for integer_square: a cycle-level arithmetic model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_integer_square;

    localparam int WIDTH      = 32;
    localparam int ROOT_WIDTH = 16;

`ifdef INTEGER_SQUARE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  stall;
    logic                  start;
    logic [ROOT_WIDTH-1:0] root;
    logic [WIDTH-1:0]      remainder;
    logic [WIDTH-1:0]      data_out;
    logic                  ready;
    logic                  busy;
    logic                  overflow;
    logic                  err;

    int checks;
    int failures;

    integer_square #(.WIDTH(WIDTH), .ROOT_WIDTH(ROOT_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .start    (start),
        .root     (root),
        .remainder(remainder),
        .data_out (data_out),
        .ready    (ready),
        .busy     (busy),
        .overflow (overflow),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation is a countdown of ROOT_WIDTH+1 edges
    // after which the arithmetic result appears.
    bit      m_init;
    bit      m_busy;
    bit      m_ready;
    bit      m_ovf;
    bit      m_err;
    longint  m_data;
    int      m_left;
    longint  p_sum;
    bit      p_bad;

    always @(posedge clk) begin
        if (rst || stall) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            m_data  = 0;
            m_left  = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
                m_data  = p_sum & 64'hFFFF_FFFF;
                m_ovf   = p_sum > 64'hFFFF_FFFF;
                m_err   = p_bad;
            end
        end else if (start) begin
            m_busy  = 1'b1;
            m_ready = 1'b0;
            m_err   = 1'b0;
            m_left  = ROOT_WIDTH + 1;
            p_sum   = longint'(root) * longint'(root) + longint'(remainder);
            p_bad   = ERR_EN && (remainder >= 32'h8000_0000 ||
                                 longint'(remainder) > 2 * longint'(root));
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", busy, m_busy);
            chk("ready", ready, m_ready);
            if (!m_busy) begin
                chk("data_out", data_out, m_data);
                chk("overflow", overflow, m_ovf);
                chk("err", err, m_err);
            end
        end
    end

    // Launch one operation; optionally pulse start again while busy.
    task automatic do_op(input logic [15:0] r, input logic [31:0] rm, input bit extra,
                         output logic [31:0] d, output logic o, output logic e,
                         output int lat);
        root      = r;
        remainder = rm;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        root      = ~r;
        remainder = ~rm;
        lat = 0;
        while (!ready && lat < 40) begin
            start = extra && (lat == 3 || lat == 10);
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        start = 1'b0;
        d = data_out;
        o = overflow;
        e = err;
    endtask

    function automatic void isqrt(input logic [31:0] x, output logic [15:0] r,
                                  output logic [31:0] rm);
        longint t;
        r = 16'd0;
        for (int b = 15; b >= 0; b--) begin
            t = longint'(r | (16'd1 << b));
            if (t * t <= longint'(x)) r = r | (16'd1 << b);
        end
        rm = 32'(longint'(x) - longint'(r) * longint'(r));
    endfunction

    logic [31:0] d;
    logic        o;
    logic        e;
    int          lat;
    logic [31:0] x;
    logic [15:0] rr;
    logic [31:0] rm;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        start     = 1'b0;
        root      = '0;
        remainder = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        chk("reset_data", data_out, 0);

        do_op(16'd0, 32'd0, 1'b0, d, o, e, lat);
        chk("t1_latency", lat, 17);
        chk("t1_data", d, 0);
        chk("t1_ovf", o, 0);
        chk("t1_err", e, 0);

        root = 16'd1234; remainder = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t2_busy_E0", busy, 1);
        repeat (16) @(posedge clk);
        #1;
        chk("t2_busy_E16", busy, 1);
        chk("t2_ready_E16", ready, 0);
        @(posedge clk); #1;
        chk("t2_busy_E17", busy, 0);
        chk("t2_ready_E17", ready, 1);
        chk("t2_data", data_out, 32'h0017_3CA8);

        do_op(16'd65535, 32'd131070, 1'b0, d, o, e, lat);
        chk("t3_data", d, 32'hFFFF_FFFF);
        chk("t3_ovf", o, 0);
        chk("t3_err", e, 0);

        do_op(16'd65535, 32'd131071, 1'b0, d, o, e, lat);
        chk("t4_data", d, 0);
        chk("t4_ovf", o, 1);
        chk("t4_err", e, ERR_EN);

        do_op(16'd5, 32'hFFFF_FFFF, 1'b0, d, o, e, lat);
        chk("t4b_data", d, 32'd24);
        chk("t4b_ovf", o, 1);
        chk("t4b_err", e, ERR_EN);

        root = 16'd7; remainder = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0;
        chk("t5_stall_busy", busy, 0);
        chk("t5_stall_ready", ready, 0);
        chk("t5_stall_data", data_out, 0);

        do_op(16'd9, 32'd0, 1'b1, d, o, e, lat);
        chk("t5_latency", lat, 17);
        chk("t5_data", d, 81);

        root = 16'd300; remainder = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", ready, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_ovf", overflow, 0);

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            isqrt(x, rr, rm);
            do_op(rr, rm, 1'b0, d, o, e, lat);
            chk("rt_data", d, x);
            chk("rt_ovf", o, 0);
            chk("rt_err", e, 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
